exec_unit_mc: RTL and testbench
===============================

Name: exec_unit_mc

Overview:
- Parametrised multi-cycle execute unit; successor to the single-cycle execute stage.
- Sits between decode/operand-fetch and memory stage.
- Computes ALU result, branch flag and branch target for any XLEN.
- Adds valid/ready handshakes on both sides, pipeline flush, and an iterative RV32M/RV64M multiply/divide engine, so the core can stall on long-latency ops.

Parameters:
- XLEN, 32, datapath width (32 or 64); shift amount width is $clog2(XLEN).
- MUL_CYCLES, XLEN, iterations of shift-add multiply; must equal XLEN (reserved for a future radix-4 variant).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts operation this cycle
- exe_fun  in  5  operation code (package encoding)
- op1_data  in  XLEN  operand 1
- op2_data  in  XLEN  operand 2
- reg_pc  in  XLEN  PC of instruction
- imm_b_sext  in  XLEN  sign-extended branch offset
- flush  in  1  kill in-flight and same-cycle op
- out_valid  out  1  result valid
- out_ready  in  1  downstream consumes result
- alu_out  out  XLEN  result
- br_flg  out  1  branch taken
- br_target  out  XLEN  reg_pc + imm_b_sext
- busy  out  1  FSM in MUL or DIV

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; alu_out, br_target, busy all 0; br_flg=0. Reset mid-MUL/DIV abandons the op; no result is emitted.
- FSM states: IDLE, MUL, DIV, RESP.
- in_ready = !flush && (state==IDLE || (state==RESP && out_ready)).
- An op is accepted when in_valid && in_ready; operands and exe_fun are captured.
- Single-cycle ops (ADD SUB AND OR XOR SLL SRL SRA SLT SLTU JALR COPY1 and all BR_*):
  - Go to RESP with results registered; out_valid rises the next cycle (latency 1).
  - Back-to-back throughput is 1 per cycle while out_ready=1.
- ALU arithmetic:
  - Results are XLEN wide, modulo 2^XLEN.
  - Shifts use op2[log2(XLEN)-1:0]; SRA is arithmetic.
  - SLT/SLTU zero-extend a 1-bit result.
  - JALR = (op1+op2) with bit 0 cleared.
  - Unknown codes give alu_out=0.
- br_flg follows BEQ/BNE/BLT/BGE/BLTU/BGEU semantics; 0 for non-branch codes. br_target is always reg_pc+imm_b_sext, modulo 2^XLEN.
- MUL, MULH, MULHSU, MULHU:
  - IDLE→MUL; one shift-add step per cycle on absolute values; sign fix-up applied on completion.
  - After exactly XLEN cycles → RESP (latency XLEN+1).
  - MUL returns the low half; the others return the high half.
- DIV, DIVU, REM, REMU:
  - Restoring division, XLEN cycles, then RESP (latency XLEN+1).
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend, remainder 0. Both special cases still take the full XLEN+1 latency.
- RESP: out_valid=1 and outputs held stable until out_ready. With out_ready=1: accept a new op if offered, otherwise go to IDLE.
- Flush (highest priority): state→IDLE and out_valid=0 next cycle. A same-cycle in_valid is not accepted (in_ready=0). A flush during RESP drops the result even if out_ready=1.
- Simultaneous out_ready and in_valid in RESP: the result is consumed and the new op accepted in the same cycle.
- in_valid while busy: ignored; in_ready=0.

Optional Feature:
- EXEC_MULDIV_EN defined: the M-extension engine (MUL/DIV states) is present as above.
- Not defined: MUL/DIV states and datapath are removed. M opcodes complete single-cycle with alu_out=0 and br_flg=0; busy is tied to 0.

Decomposition:
- Shared package core_pkg holds:
  - exe_fun encodings (ALU_*, BR_*, MUL_*, DIV_*) and the FUN_W=5 width;
  - the state enum;
  - XLEN default.
- One sub-module, muldiv_iter: iterative multiply/divide engine with start/done handshake, instantiated only under EXEC_MULDIV_EN.

Test Plan:
- ADD op1=0xFFFFFFFF, op2=1, XLEN=32 → alu_out=0x00000000, out_valid one cycle after acceptance; 4 back-to-back ops with out_ready=1 complete in 4 consecutive cycles.
- BLT op1=0xFFFFFFFE, op2=1, reg_pc=0x100, imm=0xFFFFFFF0 → br_flg=1, br_target=0x000000F0; BLTU with the same operands → br_flg=0.
- MULH op1=0x80000000, op2=0x80000000 → alu_out=0x40000000 after 33 cycles; in_ready=0 and busy=1 throughout.
- DIV op1=0x80000000, op2=0xFFFFFFFF → 0x80000000; REM → 0; DIVU op1=7, op2=0 → 0xFFFFFFFF; REMU → 7.
- out_ready held 0 for 5 cycles in RESP → alu_out and out_valid stable; new in_valid not accepted until out_ready=1.
- flush asserted at cycle 10 of DIV, together with in_valid → no out_valid; op not accepted; in_ready=1 the following cycle. rst_n pulsed mid-MUL → all outputs 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared execute-stage definitions: operation encodings, FSM states, default width.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int FUN_W        = 5;

  localparam logic [FUN_W-1:0] ALU_X      = 5'd0;
  localparam logic [FUN_W-1:0] ALU_ADD    = 5'd1;
  localparam logic [FUN_W-1:0] ALU_SUB    = 5'd2;
  localparam logic [FUN_W-1:0] ALU_AND    = 5'd3;
  localparam logic [FUN_W-1:0] ALU_OR     = 5'd4;
  localparam logic [FUN_W-1:0] ALU_XOR    = 5'd5;
  localparam logic [FUN_W-1:0] ALU_SLL    = 5'd6;
  localparam logic [FUN_W-1:0] ALU_SRL    = 5'd7;
  localparam logic [FUN_W-1:0] ALU_SRA    = 5'd8;
  localparam logic [FUN_W-1:0] ALU_SLT    = 5'd9;
  localparam logic [FUN_W-1:0] ALU_SLTU   = 5'd10;
  localparam logic [FUN_W-1:0] BR_BEQ     = 5'd11;
  localparam logic [FUN_W-1:0] BR_BNE     = 5'd12;
  localparam logic [FUN_W-1:0] BR_BLT     = 5'd13;
  localparam logic [FUN_W-1:0] BR_BGE     = 5'd14;
  localparam logic [FUN_W-1:0] BR_BLTU    = 5'd15;
  localparam logic [FUN_W-1:0] BR_BGEU    = 5'd16;
  localparam logic [FUN_W-1:0] ALU_JALR   = 5'd17;
  localparam logic [FUN_W-1:0] ALU_COPY1  = 5'd18;
  localparam logic [FUN_W-1:0] MUL_MUL    = 5'd19;
  localparam logic [FUN_W-1:0] MUL_MULH   = 5'd20;
  localparam logic [FUN_W-1:0] MUL_MULHSU = 5'd21;
  localparam logic [FUN_W-1:0] MUL_MULHU  = 5'd22;
  localparam logic [FUN_W-1:0] DIV_DIV    = 5'd23;
  localparam logic [FUN_W-1:0] DIV_DIVU   = 5'd24;
  localparam logic [FUN_W-1:0] DIV_REM    = 5'd25;
  localparam logic [FUN_W-1:0] DIV_REMU   = 5'd26;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_RESP} state_e;

  function automatic logic is_mul(input logic [FUN_W-1:0] f);
    return f inside {MUL_MUL, MUL_MULH, MUL_MULHSU, MUL_MULHU};
  endfunction

  function automatic logic is_div(input logic [FUN_W-1:0] f);
    return f inside {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU};
  endfunction

endpackage

// File: rtl/exec_unit_mc_muldiv_iter.sv
// Iterative M-extension engine: shift-add multiply / restoring divide on magnitudes,
// one step per cycle, sign fix-up folded into the combinational result on the last step.
module muldiv_iter import core_pkg::*; #(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int CYCLES = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [FUN_W-1:0] fun_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic             en_i,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o
);
  localparam int CW = $clog2(CYCLES);

  logic [FUN_W-1:0] fun_q;
  logic [XLEN-1:0]  a_q, hi_q, lo_q, dv_q, hi_d, lo_d;
  logic             neg_q, rneg_q, bzero_q;
  logic [CW-1:0]    cnt_q;

  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_abs, b_abs;
  assign a_neg = a_i[XLEN-1] && (fun_i inside {MUL_MULH, MUL_MULHSU, DIV_DIV, DIV_REM});
  assign b_neg = b_i[XLEN-1] && (fun_i inside {MUL_MULH, DIV_DIV, DIV_REM});
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;

  // mul: {hi,lo} is the product shifting in from the top; div: hi=remainder, lo=quotient
  logic [XLEN:0] sum, rs, diff;
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
    rs   = {hi_q, lo_q[XLEN-1]};
    diff = rs - {1'b0, dv_q};
    if (is_div(fun_q)) begin
      hi_d = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  always_comb begin
    prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    quo  = bzero_q ? '1  : (neg_q  ? -lo_d : lo_d);
    rem  = bzero_q ? a_q : (rneg_q ? -hi_d : hi_d);
    case (fun_q)
      MUL_MUL:           result_o = prod[XLEN-1:0];
      DIV_DIV, DIV_DIVU: result_o = quo;
      DIV_REM, DIV_REMU: result_o = rem;
      default:           result_o = prod[2*XLEN-1:XLEN];
    endcase
  end

  assign done_o = en_i && (cnt_q == CW'(CYCLES-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fun_q <= '0; a_q <= '0; hi_q <= '0; lo_q <= '0; dv_q <= '0;
      neg_q <= 1'b0; rneg_q <= 1'b0; bzero_q <= 1'b0; cnt_q <= '0;
    end else if (start_i) begin
      fun_q   <= fun_i;
      a_q     <= a_i;
      hi_q    <= '0;
      lo_q    <= is_div(fun_i) ? a_abs : b_abs;
      dv_q    <= is_div(fun_i) ? b_abs : a_abs;
      neg_q   <= a_neg ^ b_neg;
      rneg_q  <= a_neg;
      bzero_q <= is_div(fun_i) && (b_i == '0);
      cnt_q   <= '0;
    end else if (en_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute unit with valid/ready on both sides and flush.
// EXEC_MULDIV_EN adds the iterative multiply/divide engine; without it M ops return 0.
module exec_unit_mc import core_pkg::*; #(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MUL_CYCLES = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FUN_W-1:0] exe_fun,
  input  logic [XLEN-1:0]  op1_data,
  input  logic [XLEN-1:0]  op2_data,
  input  logic [XLEN-1:0]  reg_pc,
  input  logic [XLEN-1:0]  imm_b_sext,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_out,
  output logic             br_flg,
  output logic [XLEN-1:0]  br_target,
  output logic             busy
);
  localparam int SHW = $clog2(XLEN);

  if (MUL_CYCLES != XLEN) begin : g_cfg_err
    $error("MUL_CYCLES must equal XLEN");
  end

  state_e          state_q, state_d;
  logic [XLEN-1:0] alu_q, alu_d, tgt_q, tgt_d, alu_c, sum, md_res;
  logic            br_q, br_d, br_c, accept, md_done;
  logic [SHW-1:0]  shamt;

  assign in_ready  = !flush && (state_q == S_IDLE || (state_q == S_RESP && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_RESP);
  assign alu_out   = alu_q;
  assign br_flg    = br_q;
  assign br_target = tgt_q;

  assign shamt = op2_data[SHW-1:0];
  assign sum   = op1_data + op2_data;

  always_comb begin
    alu_c = '0;
    br_c  = 1'b0;
    case (exe_fun)
      ALU_ADD:   alu_c = sum;
      ALU_SUB:   alu_c = op1_data - op2_data;
      ALU_AND:   alu_c = op1_data & op2_data;
      ALU_OR:    alu_c = op1_data | op2_data;
      ALU_XOR:   alu_c = op1_data ^ op2_data;
      ALU_SLL:   alu_c = op1_data << shamt;
      ALU_SRL:   alu_c = op1_data >> shamt;
      ALU_SRA:   alu_c = $signed(op1_data) >>> shamt;
      ALU_SLT:   alu_c = {{(XLEN-1){1'b0}}, $signed(op1_data) < $signed(op2_data)};
      ALU_SLTU:  alu_c = {{(XLEN-1){1'b0}}, op1_data < op2_data};
      ALU_JALR:  alu_c = {sum[XLEN-1:1], 1'b0};
      ALU_COPY1: alu_c = op1_data;
      BR_BEQ:    br_c  = (op1_data == op2_data);
      BR_BNE:    br_c  = (op1_data != op2_data);
      BR_BLT:    br_c  = $signed(op1_data) <  $signed(op2_data);
      BR_BGE:    br_c  = $signed(op1_data) >= $signed(op2_data);
      BR_BLTU:   br_c  = op1_data <  op2_data;
      BR_BGEU:   br_c  = op1_data >= op2_data;
      default: ;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  assign busy = (state_q == S_MUL) || (state_q == S_DIV);

  muldiv_iter #(.XLEN(XLEN), .CYCLES(MUL_CYCLES)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && (is_mul(exe_fun) || is_div(exe_fun))),
    .fun_i    (exe_fun),
    .a_i      (op1_data),
    .b_i      (op2_data),
    .en_i     (busy),
    .done_o   (md_done),
    .result_o (md_res)
  );
`else
  assign busy    = 1'b0;
  assign md_done = 1'b0;
  assign md_res  = '0;
`endif

  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    br_d    = br_q;
    tgt_d   = tgt_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            alu_d   = alu_c;
            br_d    = br_c;
            tgt_d   = reg_pc + imm_b_sext;
            state_d = S_RESP;
`ifdef EXEC_MULDIV_EN
            if (is_mul(exe_fun))      state_d = S_MUL;
            else if (is_div(exe_fun)) state_d = S_DIV;
`endif
          end else if (state_q == S_RESP && out_ready) begin
            state_d = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (md_done) begin
            alu_d   = md_res;
            state_d = S_RESP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      alu_q   <= '0;
      br_q    <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      br_q    <= br_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc (XLEN=32); M-extension cases depend on EXEC_MULDIV_EN.
module tb_exec_unit_mc;
  import core_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, flush, out_valid, out_ready, br_flg, busy;
  logic [FUN_W-1:0] exe_fun;
  logic [31:0]      op1_data, op2_data, reg_pc, imm_b_sext, alu_out, br_target;

  int n_cmp = 0;
  int n_err = 0;

  exec_unit_mc #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exe_fun(exe_fun), .op1_data(op1_data), .op2_data(op2_data),
    .reg_pc(reg_pc), .imm_b_sext(imm_b_sext), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .br_flg(br_flg), .br_target(br_target), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [FUN_W-1:0] f, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    exe_fun  = f;
    op1_data = a;
    op2_data = b;
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic run_mc(input string tag, input logic [FUN_W-1:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    drive(f, a, b);
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 33);
    chk(tag, alu_out, exp);
    step();
  endtask
`endif

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; exe_fun = '0; op1_data = '0; op2_data = '0;
    reg_pc = '0; imm_b_sext = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_br_flg", br_flg, 0);
    chk("rst_br_target", br_target, 0);
    chk("rst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // wrap-around add, then a back-to-back chain with out_ready=1
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'h1); reg_pc = 32'h200; imm_b_sext = 32'h4;
    #1 chk("add_in_ready", in_ready, 1);
    step();
    chk("add_valid", out_valid, 1);
    chk("add_wrap", alu_out, 32'h0);
    chk("add_target", br_target, 32'h204);
    drive(ALU_ADD, 32'd5, 32'd3);                   step();
    chk("b2b_valid1", out_valid, 1); chk("b2b_add", alu_out, 32'd8);
    drive(ALU_SUB, 32'd3, 32'd5);                   step();
    chk("b2b_valid2", out_valid, 1); chk("b2b_sub", alu_out, 32'hFFFF_FFFE);
    drive(ALU_SLL, 32'd1, 32'd33);                  step();
    chk("b2b_valid3", out_valid, 1); chk("b2b_sll", alu_out, 32'd2);
    drive(ALU_SRA, 32'h8000_0000, 32'd4);           step();
    chk("b2b_valid4", out_valid, 1); chk("b2b_sra", alu_out, 32'hF800_0000);
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1);           step(); chk("slt", alu_out, 32'd1);
    drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);          step(); chk("sltu", alu_out, 32'd0);
    drive(ALU_JALR, 32'h1001, 32'd2);               step(); chk("jalr", alu_out, 32'h1002);
    drive(ALU_XOR, 32'hF0F0, 32'hFF00);             step(); chk("xor", alu_out, 32'h0FF0);
    drive(ALU_SRL, 32'h8000_0000, 32'd31);          step(); chk("srl", alu_out, 32'd1);
    drive(5'd31, 32'h1234, 32'h5678);               step(); chk("unknown", alu_out, 32'd0);
    in_valid = 1'b0;                                step(); chk("drain_idle", out_valid, 0);

    // branches
    drive(BR_BLT, 32'hFFFF_FFFE, 32'd1); reg_pc = 32'h100; imm_b_sext = 32'hFFFF_FFF0;
    step(); chk("blt_flg", br_flg, 1); chk("blt_target", br_target, 32'hF0);
    drive(BR_BLTU, 32'hFFFF_FFFE, 32'd1);
    step(); chk("bltu_flg", br_flg, 0); chk("bltu_target", br_target, 32'hF0);
    drive(BR_BEQ, 32'd5, 32'd5);                    step(); chk("beq_flg", br_flg, 1);
    drive(BR_BGE, 32'hFFFF_FFFE, 32'd1);            step(); chk("bge_flg", br_flg, 0);
    drive(ALU_ADD, 32'd1, 32'd1);                   step(); chk("nonbr_flg", br_flg, 0);
    in_valid = 1'b0;                                step();

    // downstream stall holds the result
    drive(ALU_ADD, 32'd10, 32'd20); step();
    out_ready = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_in_ready", in_ready, 0);
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_alu", alu_out, 32'd30);
    end
    out_ready = 1'b1;
    #1 chk("unstall_in_ready", in_ready, 1);
    step();
    chk("unstall_valid", out_valid, 1); chk("unstall_alu", alu_out, 32'd2);
    in_valid = 1'b0; step(); chk("unstall_idle", out_valid, 0);

    // flush in RESP drops the result and blocks the same-cycle op
    drive(ALU_ADD, 32'd2, 32'd2); step(); chk("pre_flush_valid", out_valid, 1);
    flush = 1'b1; drive(ALU_ADD, 32'd7, 32'd7);
    #1 chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    #1 chk("post_flush_ready", in_ready, 1);
    step(); chk("flush_no_accept", out_valid, 0);

`ifdef EXEC_MULDIV_EN
    // MULH with in_valid held during the busy window
    drive(MUL_MULH, 32'h8000_0000, 32'h8000_0000); step();
    drive(ALU_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 32; i++) begin
      chk("mulh_busy", busy, 1);
      chk("mulh_in_ready", in_ready, 0);
      chk("mulh_valid_low", out_valid, 0);
      if (i == 31) in_valid = 1'b0;
      step();
    end
    chk("mulh_valid", out_valid, 1);
    chk("mulh", alu_out, 32'h4000_0000);
    step();
    run_mc("mul",    MUL_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    run_mc("mulhu",  MUL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mc("mulhsu", MUL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mc("div_ovf",  DIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mc("rem_ovf",  DIV_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_mc("divu_z",   DIV_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_mc("remu_z",   DIV_REMU, 32'd7, 32'd0, 32'd7);
    run_mc("div_neg",  DIV_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_mc("rem_neg",  DIV_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_mc("div_z",    DIV_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_mc("rem_z",    DIV_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

    // flush on the 10th DIV cycle together with a new op
    drive(DIV_DIVU, 32'd100, 32'd7); step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1; drive(ALU_ADD, 32'd1, 32'd1);
    #1 chk("divflush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("divflush_busy", busy, 0);
    #1 chk("divflush_ready_next", in_ready, 1);
    seen = 1'b0;
    repeat (36) begin step(); seen |= out_valid; end
    chk("divflush_no_result", seen, 0);

    // reset in the middle of a multiply
    reg_pc = 32'h300; imm_b_sext = 32'h20;
    drive(MUL_MUL, 32'd3, 32'd5); step();
    in_valid = 1'b0;
    chk("mulrst_target_before", br_target, 32'h320);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("mulrst_valid", out_valid, 0); chk("mulrst_alu", alu_out, 0);
    chk("mulrst_target", br_target, 0); chk("mulrst_busy", busy, 0);
    chk("mulrst_br", br_flg, 0);
    step(); rst_n = 1'b1;
    seen = 1'b0;
    repeat (36) begin step(); seen |= out_valid; end
    chk("mulrst_no_result", seen, 0);
`else
    // without the engine, M ops complete in one cycle with a zero result
    drive(MUL_MUL, 32'd3, 32'd5); step();
    chk("nomd_mul_valid", out_valid, 1); chk("nomd_mul", alu_out, 0); chk("nomd_busy", busy, 0);
    drive(DIV_DIVU, 32'd7, 32'd0); step();
    chk("nomd_divu_valid", out_valid, 1); chk("nomd_divu", alu_out, 0); chk("nomd_br", br_flg, 0);
    in_valid = 1'b0; step();
`endif

    // reset while holding a result
    reg_pc = 32'h100; imm_b_sext = 32'h10;
    drive(ALU_ADD, 32'd3, 32'd4); step();
    chk("resprst_alu_before", alu_out, 32'd7);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("resprst_valid", out_valid, 0); chk("resprst_alu", alu_out, 0);
    chk("resprst_target", br_target, 0);
    step(); rst_n = 1'b1; out_ready = 1'b1;
    step(); chk("resprst_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
